// File: rtl/e_mdu_ctrl.sv
// e_mdu_ctrl: E-stage multiply/divide unit and HI/LO scheduler.
// A single issued op computes its result up front. A busy counter then models the
// fixed latency before the result commits to architectural HI/LO.
// Optional feature macro: MDU_MADD_EN enables madd/maddu/msub/msubu (MDOp 7-10).
module e_mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        Start,
  input  logic [3:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        MdUse,
  output logic        Busy,
  output logic        Stall,
  output logic [31:0] HiOut,
  output logic [31:0] LoOut
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OpMadd  = 4'd7;
  localparam logic [3:0] OpMaddu = 4'd8;
  localparam logic [3:0] OpMsub  = 4'd9;
  localparam logic [3:0] OpMsubu = 4'd10;
`endif

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;
  logic [31:0]       pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;

  logic              is_signed, op_valid, issue;
  logic [63:0]       mul_a, mul_b, prod;
  logic              a_neg, b_neg;
  logic [31:0]       abs_a, abs_b, div_b, q_mag, r_mag, quot, rem;
`ifdef MDU_MADD_EN
  logic [63:0]       acc_add, acc_sub;
`endif

  // Operand decode, shared multiplier and sign-magnitude divider.
  always_comb begin
    is_signed = (MDOp == OpMult) || (MDOp == OpDiv);
    op_valid  = (MDOp >= OpMult) && (MDOp <= OpMtlo);
`ifdef MDU_MADD_EN
    is_signed = is_signed || (MDOp == OpMadd) || (MDOp == OpMsub);
    op_valid  = op_valid || ((MDOp >= OpMadd) && (MDOp <= OpMsubu));
`endif
    // Low 64 bits of the product of sign/zero-extended operands are exact for both forms.
    mul_a = {{32{is_signed & A[31]}}, A};
    mul_b = {{32{is_signed & B[31]}}, B};
    prod  = mul_a * mul_b;
    // Magnitude division; 0x8000_0000 / -1 falls out as 0x8000_0000 rem 0 naturally.
    a_neg = is_signed & A[31];
    b_neg = is_signed & B[31];
    abs_a = a_neg ? (32'd0 - A) : A;
    abs_b = b_neg ? (32'd0 - B) : B;
    div_b = (abs_b == 32'd0) ? 32'd1 : abs_b;
    q_mag = abs_a / div_b;
    r_mag = abs_a % div_b;
    quot  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem   = a_neg ? (32'd0 - r_mag) : r_mag;
`ifdef MDU_MADD_EN
    acc_add = {hi_q, lo_q} + prod;
    acc_sub = {hi_q, lo_q} - prod;
`endif
  end

  assign issue = Start & ~Req & (state_q == StIdle) & op_valid;

  // Next-state: issue from idle, count down in run, commit pending result on last cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    unique case (state_q)
      StIdle: begin
        if (issue) begin
          case (MDOp)
            OpMthi: hi_d = A;
            OpMtlo: lo_d = A;
            OpMult, OpMultu: begin
              {pend_hi_d, pend_lo_d} = prod;
              cnt_d   = CntW'(MULT_CYCLES);
              state_d = StRun;
            end
            OpDiv, OpDivu: begin
              // Divide by zero still occupies the unit but recommits the current HI/LO.
              if (B == 32'd0) {pend_hi_d, pend_lo_d} = {hi_q, lo_q};
              else            {pend_hi_d, pend_lo_d} = {rem, quot};
              cnt_d   = CntW'(DIV_CYCLES);
              state_d = StRun;
            end
`ifdef MDU_MADD_EN
            OpMadd, OpMaddu: begin
              {pend_hi_d, pend_lo_d} = acc_add;
              cnt_d   = CntW'(MULT_CYCLES);
              state_d = StRun;
            end
            OpMsub, OpMsubu: begin
              {pend_hi_d, pend_lo_d} = acc_sub;
              cnt_d   = CntW'(MULT_CYCLES);
              state_d = StRun;
            end
`endif
            default: ;
          endcase
        end
      end
      StRun: begin
        if (cnt_q == CntW'(1)) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset; reset discards any in-flight op.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  assign Busy  = (state_q == StRun);
  assign Stall = MdUse & (Start | Busy);
  assign HiOut = hi_q;
  assign LoOut = lo_q;

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// Directed bench for e_mdu_ctrl with hand-computed expected values.
module tb_e_mdu_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Req = 1'b0;
  logic        Start = 1'b0;
  logic [3:0]  MDOp = 4'd0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        MdUse = 1'b0;
  logic        Busy, Stall;
  logic [31:0] HiOut, LoOut;

  int n_checks = 0;
  int n_errors = 0;

  e_mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Req   (Req),
    .Start (Start),
    .MDOp  (MDOp),
    .A     (A),
    .B     (B),
    .MdUse (MdUse),
    .Busy  (Busy),
    .Stall (Stall),
    .HiOut (HiOut),
    .LoOut (LoOut)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Issue one op, then count Busy cycles (bounded), optionally pulsing Req in busy cycle req_at.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_n, input int req_at);
    int n;
    Start = 1'b1; MDOp = op; A = a; B = b; MdUse = 1'b1;
    #1;
    check_eq({tag, "_stall_issue"}, {31'd0, Stall}, 32'd1);
    tick();
    Start = 1'b0; MDOp = 4'd0;
    #1;
    check_eq({tag, "_stall_after"}, {31'd0, Stall}, (exp_n != 0) ? 32'd1 : 32'd0);
    MdUse = 1'b0;
    n = 0;
    while (Busy && n < 100) begin
      n++;
      Req = (n == req_at);
      tick();
    end
    Req = 1'b0;
    check_eq({tag, "_busy_cycles"}, n, exp_n);
  endtask

  initial begin
    // Reset behaviour, including combinational Stall while held in reset.
    tick(); tick();
    check_eq("rst_busy", {31'd0, Busy}, 32'd0);
    check_eq("rst_hi", HiOut, 32'd0);
    check_eq("rst_lo", LoOut, 32'd0);
    MdUse = 1'b1; Start = 1'b1; #1;
    check_eq("rst_stall_start", {31'd0, Stall}, 32'd1);
    Start = 1'b0; #1;
    check_eq("rst_stall_idle", {31'd0, Stall}, 32'd0);
    MdUse = 1'b0;
    Reset = 1'b0;
    tick();

    run_op("mult", 4'd1, 32'hFFFF_FFFD, 32'd5, 5, 0);
    check_eq("mult_hi", HiOut, 32'hFFFF_FFFF);
    check_eq("mult_lo", LoOut, 32'hFFFF_FFF1);

    run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 0);
    check_eq("multu_hi", HiOut, 32'hFFFF_FFFE);
    check_eq("multu_lo", LoOut, 32'h0000_0001);

    run_op("divu", 4'd4, 32'd7, 32'd2, 10, 0);
    check_eq("divu_hi", HiOut, 32'd1);
    check_eq("divu_lo", LoOut, 32'd3);

    run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 10, 0);
    check_eq("div_hi", HiOut, 32'hFFFF_FFFF);
    check_eq("div_lo", LoOut, 32'hFFFF_FFFD);

    run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 0);
    check_eq("div_ovf_hi", HiOut, 32'd0);
    check_eq("div_ovf_lo", LoOut, 32'h8000_0000);

    // Divide by zero keeps HI/LO.
    run_op("mthi11", 4'd5, 32'h11, 32'd0, 0, 0);
    run_op("mtlo22", 4'd6, 32'h22, 32'd0, 0, 0);
    check_eq("mt_hi", HiOut, 32'h11);
    check_eq("mt_lo", LoOut, 32'h22);
    run_op("div0", 4'd3, 32'd9, 32'd0, 10, 0);
    check_eq("div0_hi", HiOut, 32'h11);
    check_eq("div0_lo", LoOut, 32'h22);

    // Req in the issue cycle blocks the op entirely.
    Start = 1'b1; MDOp = 4'd1; A = 32'd3; B = 32'd3; Req = 1'b1;
    tick();
    Start = 1'b0; MDOp = 4'd0; Req = 1'b0;
    check_eq("req_issue_busy", {31'd0, Busy}, 32'd0);
    tick();
    check_eq("req_issue_hi", HiOut, 32'h11);
    check_eq("req_issue_lo", LoOut, 32'h22);

    // Req during run is ignored.
    run_op("mult_req", 4'd1, 32'h0001_0000, 32'h0001_0000, 5, 2);
    check_eq("mult_req_hi", HiOut, 32'd1);
    check_eq("mult_req_lo", LoOut, 32'd0);

    // Reset in RUN cycle 3 of a div discards it.
    Start = 1'b1; MDOp = 4'd4; A = 32'd100; B = 32'd7;
    tick();
    Start = 1'b0; MDOp = 4'd0;
    tick(); tick();
    check_eq("rst_run_busy_pre", {31'd0, Busy}, 32'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check_eq("rst_run_busy", {31'd0, Busy}, 32'd0);
    check_eq("rst_run_hi", HiOut, 32'd0);
    check_eq("rst_run_lo", LoOut, 32'd0);
    for (int i = 0; i < 12; i++) tick();
    check_eq("rst_run_late_busy", {31'd0, Busy}, 32'd0);
    check_eq("rst_run_late_hi", HiOut, 32'd0);
    check_eq("rst_run_late_lo", LoOut, 32'd0);

    // mthi followed by mfhi in D: no stall next cycle.
    Start = 1'b1; MDOp = 4'd5; A = 32'hABCD;
    tick();
    Start = 1'b0; MDOp = 4'd0; MdUse = 1'b1;
    #1;
    check_eq("mthi_stall", {31'd0, Stall}, 32'd0);
    check_eq("mthi_hi", HiOut, 32'hABCD);
    MdUse = 1'b0;

    // Accumulate ops.
    run_op("mthi0", 4'd5, 32'd0, 32'd0, 0, 0);
    run_op("mtloF", 4'd6, 32'hFFFF_FFFF, 32'd0, 0, 0);
`ifdef MDU_MADD_EN
    run_op("madd", 4'd7, 32'd1, 32'd1, 5, 0);
    check_eq("madd_hi", HiOut, 32'd1);
    check_eq("madd_lo", LoOut, 32'd0);
    run_op("msub", 4'd9, 32'd1, 32'd1, 5, 0);
    check_eq("msub_hi", HiOut, 32'd0);
    check_eq("msub_lo", LoOut, 32'hFFFF_FFFF);
`else
    run_op("madd", 4'd7, 32'd1, 32'd1, 0, 0);
    check_eq("madd_hi", HiOut, 32'd0);
    check_eq("madd_lo", LoOut, 32'hFFFF_FFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
